sorted_index_gather: RTL and testbench
======================================

Name: sorted_index_gather

Overview:
- Downstream consumer of the index-sorting network built from registered compare-and-swap stages.
- Accepts one frame: the original unsorted data vector plus the sorted index vector produced by the network. Captures both, then streams the frame out one element per beat in sorted order.
- Each beat carries the data word and its original index, with valid/ready handshake and a last flag.
- Also checks that the index vector is a true permutation, to catch sorter or pipeline-alignment faults.

Parameters:
- DATA_WIDTH, 32, width of one data element
- N_INPUTS, 8, elements per frame (power of two, ≥2)
- INDEX_WIDTH, $clog2(N_INPUTS), width of one index

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  frame offered
- in_ready  output  1  frame accepted when in_valid & in_ready
- in_data  input  N_INPUTS*DATA_WIDTH  unsorted data; element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- in_index  input  N_INPUTS*INDEX_WIDTH  sorted index vector; slot 0 is emitted first
- out_valid  output  1  beat available
- out_ready  input  1  downstream accepts beat
- out_data  output  DATA_WIDTH  in_data element selected by the current sorted index
- out_index  output  INDEX_WIDTH  that original index
- out_last  output  1  high on the final beat of a frame (slot N_INPUTS-1)
- perm_err  output  1  current frame's index vector contains a duplicate
- busy  output  1  state==STREAM

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, beat counter cnt=0.
  - Data and index buffers cleared to 0.
  - out_valid=0, out_last=0, perm_err=0, busy=0; out_data and out_index read 0.
- FSM states: IDLE, STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: capture in_data → dbuf and in_index → ibuf; compute perm_err from in_index (any two slots equal → 1) and register it; cnt=0; go to STREAM.
- STREAM:
  - out_valid=1.
  - out_index=ibuf[cnt] and out_data=dbuf[ibuf[cnt]], both muxed from registers only. There is no combinational path from in_* to out_*.
  - out_last=(cnt==N_INPUTS-1). perm_err is held constant for the whole frame.
  - On out_valid & out_ready with !out_last: cnt++.
  - On the last beat accepted: if in_valid, capture the new frame the same cycle (cnt=0, stay in STREAM, new perm_err); otherwise go to IDLE with perm_err cleared.
  - Stall (out_ready=0): outputs hold stable; cnt and buffers do not change.
- in_ready = (state==IDLE) | (state==STREAM & out_last & out_ready). This is a combinational dependency on out_ready, documented for integration.
- in_valid while STREAM and not on the last accepted beat: ignored (in_ready=0), so no frame is lost.
- Latency: frame accepted at edge t → first beat valid in cycle t+1. A frame of N beats with out_ready held high occupies exactly N cycles. Back-to-back frames have no bubble.
- A duplicate index is still streamed as-is (repeat element emitted); only perm_err flags it.
- Index width rule: the INDEX_WIDTH value is used directly as the mux select. N_INPUTS being a power of two guarantees every code is in range.
- rst asserted mid-frame: the frame is discarded immediately, outputs return to reset values, and the next in_valid starts a fresh frame.

Test Plan:
- Reset mid-stream: assert rst after beat 3 → out_valid=0, busy=0, out_data=0 the same cycle. After release, a new frame streams from slot 0.
- Basic frame, N=8, out_ready=1:
  - Stimulus: in_data={70,10,50,30,80,20,60,40} (elements 0..7), in_index={1,5,3,7,2,6,0,4}.
  - Required out_data sequence: 10,20,30,40,50,60,70,80. out_index sequence: 1,5,3,7,2,6,0,4.
  - out_last only on beat 8; first beat one cycle after accept; perm_err=0.
- Backpressure: same frame, out_ready toggled 1,0,0,1,... → each beat held stable during stalls. Exactly 8 accepted beats in the same order, with no duplicates or skips.
- Back-to-back: second frame held on in_valid during frame 1.
  - in_ready=1 only in the cycle beat 8 is accepted.
  - Frame 2 beat 1 appears the next cycle with no idle gap.
- Permutation fault: in_index={2,2,0,1,3,4,5,6} → perm_err=1 for all 8 beats; beats 1 and 2 both carry element 2. perm_err=0 again in IDLE.

Source files
------------

// File: rtl/sorted_index_gather.sv
// sorted_index_gather: captures one unsorted data frame together with the
// sorted index vector from the sorting network. It then streams the elements
// out in sorted order, one beat per cycle, and flags index vectors that are
// not permutations.
module sorted_index_gather #(
    parameter int DATA_WIDTH  = 32,
    parameter int N_INPUTS    = 8,
    parameter int INDEX_WIDTH = $clog2(N_INPUTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_INPUTS*DATA_WIDTH-1:0]  in_data,
    input  logic [N_INPUTS*INDEX_WIDTH-1:0] in_index,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [INDEX_WIDTH-1:0]          out_index,
    output logic                            out_last,
    output logic                            perm_err,
    output logic                            busy
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_SLOT = INDEX_WIDTH'(N_INPUTS - 1);

    state_t                               state, state_nxt;
    logic [N_INPUTS-1:0][DATA_WIDTH-1:0]  dbuf;
    logic [N_INPUTS-1:0][INDEX_WIDTH-1:0] ibuf;
    logic [INDEX_WIDTH-1:0]               cnt;
    logic                                 dup;
    logic                                 last_acc;
    logic                                 accept;

    // Duplicate detection across all slot pairs of the incoming index vector.
    // With N_INPUTS a power of two every code is in range, so "no duplicate"
    // is the same as "is a permutation".
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < N_INPUTS; i++)
            for (int j = i + 1; j < N_INPUTS; j++)
                if (in_index[i*INDEX_WIDTH +: INDEX_WIDTH] ==
                    in_index[j*INDEX_WIDTH +: INDEX_WIDTH])
                    dup = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and handshake outputs. in_ready depends combinationally
    // on out_ready during the last beat, so back-to-back frames have no bubble.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        last_acc  = 1'b0;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = STREAM;
            end
            STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (cnt == LAST_SLOT);
                last_acc  = out_last & out_ready;
                in_ready  = last_acc;
                if (last_acc && !in_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Output mux is driven from registers only and reads zero outside STREAM.
    assign out_index = busy ? ibuf[cnt]       : '0;
    assign out_data  = busy ? dbuf[ibuf[cnt]] : '0;

    // Frame capture, beat counter and permutation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbuf     <= '0;
            ibuf     <= '0;
            cnt      <= '0;
            perm_err <= 1'b0;
        end else if (accept) begin
            dbuf     <= in_data;
            ibuf     <= in_index;
            cnt      <= '0;
            perm_err <= dup;
        end else if (out_valid && out_ready && !out_last) begin
            cnt <= cnt + 1'b1;
        end else if (last_acc) begin
            cnt      <= '0;
            perm_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sorted_index_gather.sv
// Directed bench for sorted_index_gather (N_INPUTS=8, DATA_WIDTH=32).
module tb_sorted_index_gather;

    localparam int DW = 32;
    localparam int N  = 8;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_data;
    logic [N*IW-1:0] in_index;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_index;
    logic            out_last;
    logic            perm_err;
    logic            busy;

    int checks = 0;
    int errors = 0;

    sorted_index_gather #(.DATA_WIDTH(DW), .N_INPUTS(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_index(in_index),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index),
        .out_last(out_last), .perm_err(perm_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Basic frame and its hand-derived sorted output.
    int bd[8]  = '{70, 10, 50, 30, 80, 20, 60, 40};
    int bi[8]  = '{1, 5, 3, 7, 2, 6, 0, 4};
    int bod[8] = '{10, 20, 30, 40, 50, 60, 70, 80};

    function automatic logic [N*DW-1:0] pack_d(input int v[8]);
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(v[k]);
        return r;
    endfunction

    function automatic logic [N*IW-1:0] pack_i(input int v[8]);
        logic [N*IW-1:0] r;
        for (int k = 0; k < N; k++) r[k*IW +: IW] = IW'(v[k]);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_index = '0;
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 ||
            perm_err !== 1'b0 || out_data !== '0 || out_index !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b b=%b l=%b p=%b d=%0d i=%0d, want all 0",
                     out_valid, busy, out_last, perm_err, out_data, out_index);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_data = pack_d(bd); in_index = pack_i(bi); in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_accept: in_ready got %b want 1", in_ready);
        end
        @(negedge clk); in_valid = 1'b0; #1;
        for (int b = 0; b < N; b++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(bod[b]) || out_index !== IW'(bi[b]) ||
                out_last !== (b == N-1) || perm_err !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_beat%0d: got v=%b d=%0d i=%0d l=%b p=%b, want v=1 d=%0d i=%0d l=%b p=0",
                         b, out_valid, out_data, out_index, out_last, perm_err, bod[b], bi[b], b == N-1);
            end
            @(negedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got v=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int cyc = 0;
        out_ready = 1'b1;
        in_data = pack_d(bd); in_index = pack_i(bi); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        while (acc < N && cyc < 60) begin
            out_ready = (cyc % 3 == 0);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(bod[acc]) || out_index !== IW'(bi[acc]) ||
                out_last !== (acc == N-1)) begin
                errors++;
                $display("FAIL bp_beat%0d_cyc%0d: got v=%b d=%0d i=%0d l=%b, want v=1 d=%0d i=%0d l=%b",
                         acc, cyc, out_valid, out_data, out_index, out_last, bod[acc], bi[acc], acc == N-1);
            end
            if (out_valid && out_ready) acc++;
            cyc++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (acc !== N || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_count: accepted %0d v=%b, want %0d v=0", acc, out_valid, N);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int d2[8];
        int i2[8] = '{7, 6, 5, 4, 3, 2, 1, 0};
        for (int k = 0; k < N; k++) d2[k] = 100 + k;
        out_ready = 1'b1;
        in_data = pack_d(bd); in_index = pack_i(bi); in_valid = 1'b1;
        @(negedge clk);
        in_data = pack_d(d2); in_index = pack_i(i2);
        #1;
        for (int b = 0; b < N; b++) begin
            checks++;
            if (in_ready !== (b == N-1) || out_data !== DW'(bod[b])) begin
                errors++;
                $display("FAIL b2b_f1_beat%0d: got rdy=%b d=%0d, want rdy=%b d=%0d",
                         b, in_ready, out_data, b == N-1, bod[b]);
            end
            @(negedge clk); #1;
        end
        in_valid = 1'b0;
        for (int b = 0; b < N; b++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(107 - b) || out_index !== IW'(7 - b) ||
                out_last !== (b == N-1)) begin
                errors++;
                $display("FAIL b2b_f2_beat%0d: got v=%b d=%0d i=%0d l=%b, want v=1 d=%0d i=%0d l=%b",
                         b, out_valid, out_data, out_index, out_last, 107 - b, 7 - b, b == N-1);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_perm_fault();
        int pi[8]  = '{2, 2, 0, 1, 3, 4, 5, 6};
        int pod[8] = '{50, 50, 70, 10, 30, 80, 20, 60};
        out_ready = 1'b1;
        in_data = pack_d(bd); in_index = pack_i(pi); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; #1;
        for (int b = 0; b < N; b++) begin
            checks++;
            if (perm_err !== 1'b1 || out_data !== DW'(pod[b]) || out_index !== IW'(pi[b])) begin
                errors++;
                $display("FAIL perm_beat%0d: got p=%b d=%0d i=%0d, want p=1 d=%0d i=%0d",
                         b, perm_err, out_data, out_index, pod[b], pi[b]);
            end
            @(negedge clk); #1;
        end
        checks++;
        if (perm_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL perm_idle: got p=%b v=%b want 0 0", perm_err, out_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b1;
        in_data = pack_d(bd); in_index = pack_i(bi); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got v=%b b=%b d=%0d l=%b, want 0 0 0 0",
                     out_valid, busy, out_data, out_last);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_stays_idle: out_valid got %b want 0", out_valid);
        end
        in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; #1;
        for (int b = 0; b < N; b++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(bod[b]) || out_index !== IW'(bi[b])) begin
                errors++;
                $display("FAIL midrst_beat%0d: got v=%b d=%0d i=%0d, want v=1 d=%0d i=%0d",
                         b, out_valid, out_data, out_index, bod[b], bi[b]);
            end
            @(negedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_perm_fault();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
